// File: rtl/parport_engine_if.sv
// Host-side and pad-side signal bundle for the parallel port engine.
// slave = engine, master = register logic / pad model driving it.
interface parport_engine_if #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              flush;
   logic              mode;
   logic              full;
   logic [LVL_W-1:0]  level;
   logic              idle;
   logic              timeout;
   logic              timeout_clr;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              pp_data_oe;
   logic [DATA_W-1:0] pp_data_out;
   logic [DATA_W-1:0] pp_data_in;
   logic              pp_strobe_oe;
   logic              pp_strobe_out;
   logic              pp_strobe_in;
   logic              pp_busy;

   modport slave (
      input  wr_en, wr_data, flush, mode, timeout_clr,
      input  pp_data_in, pp_strobe_in, pp_busy,
      output full, level, idle, timeout, rd_valid, rd_data,
      output pp_data_oe, pp_data_out, pp_strobe_oe, pp_strobe_out
   );

   modport master (
      output wr_en, wr_data, flush, mode, timeout_clr,
      output pp_data_in, pp_strobe_in, pp_busy,
      input  full, level, idle, timeout, rd_valid, rd_data,
      input  pp_data_oe, pp_data_out, pp_strobe_oe, pp_strobe_out
   );
endinterface

// File: rtl/parport_engine.sv
// Centronics-style parallel port engine: TX FIFO replayed with programmable
// setup/strobe/hold timing and busy handshake, plus strobed input capture.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | no transfer; pops next byte in output mode, captures in input mode
// WAIT_BUSY  | byte on pads, waiting for synced busy low (timeout counter runs)
// SETUP      | data stable, strobe high, SETUP_CYC cycles
// STROBE     | strobe driven low for STROBE_CYC cycles
// HOLD       | strobe high, data held for HOLD_CYC cycles
module parport_engine #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int SETUP_CYC  = 16,
   parameter int STROBE_CYC = 32,
   parameter int HOLD_CYC   = 16,
   parameter int TIMEOUT_W  = 20
) (
   input  logic              clk32,
   input  logic              por_n,
   parport_engine_if.slave   bus
);
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = AW + 1;
   localparam int PH_MAX = (SETUP_CYC > STROBE_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam logic [PH_W-1:0] SETUP_LD  = PH_W'(SETUP_CYC - 1);
   localparam logic [PH_W-1:0] STROBE_LD = PH_W'(STROBE_CYC - 1);
   localparam logic [PH_W-1:0] HOLD_LD   = PH_W'(HOLD_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_WAIT_BUSY, ST_SETUP, ST_STROBE, ST_HOLD
   } state_t;

   state_t state_q, state_d;

   logic [DATA_W-1:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]     count_q, count_d;
   logic [PH_W-1:0]      tmr_q, tmr_d;
   logic [TIMEOUT_W-1:0] bw_q, bw_d;
   logic [DATA_W-1:0]    data_q, data_d, rd_data_q, rd_data_d;
   logic busy_m_q, busy_m_d, busy_s_q, busy_s_d;
   logic stb_m_q, stb_m_d, stb_s_q, stb_s_d, stb_p_q, stb_p_d;
   logic cap_q, cap_d, rd_valid_q, rd_valid_d;
   logic mode_q, mode_d, oe_q, oe_d, strobe_q, strobe_d;
   logic timeout_q, timeout_d, idle_q, idle_d;
   logic full, empty, push, pop, tmo_set;

   assign full  = (count_q == LVL_W'(FIFO_DEPTH));
   assign empty = (count_q == '0);
   assign push  = bus.wr_en && !full;

   always_ff @(posedge clk32 or negedge por_n) begin
      if (!por_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (!mode_q && !empty) state_d = ST_WAIT_BUSY;
         ST_WAIT_BUSY: if (!busy_s_q)         state_d = ST_SETUP;
         ST_SETUP:     if (tmr_q == '0)       state_d = ST_STROBE;
         ST_STROBE:    if (tmr_q == '0)       state_d = ST_HOLD;
         ST_HOLD:      if (tmr_q == '0)       state_d = ST_IDLE;
         default:                             state_d = ST_IDLE;
      endcase
   end

   // The busy counter runs down from all-ones; timeout fires as it reaches zero,
   // and the byte keeps waiting.
   always_comb begin
      pop     = 1'b0;
      tmo_set = 1'b0;
      tmr_d   = tmr_q;
      bw_d    = bw_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (state_d == ST_WAIT_BUSY) begin
               pop    = 1'b1;
               data_d = fifo_mem[rd_ptr_q];
               bw_d   = '1;
            end
         end
         ST_WAIT_BUSY: begin
            if (!busy_s_q) begin
               tmr_d = SETUP_LD;
            end else begin
               if (bw_q == TIMEOUT_W'(1)) tmo_set = 1'b1;
               if (bw_q != '0) bw_d = bw_q - TIMEOUT_W'(1);
            end
         end
         ST_SETUP:  tmr_d = (tmr_q == '0) ? STROBE_LD : tmr_q - PH_W'(1);
         ST_STROBE: tmr_d = (tmr_q == '0) ? HOLD_LD   : tmr_q - PH_W'(1);
         ST_HOLD:   if (tmr_q != '0) tmr_d = tmr_q - PH_W'(1);
         default: ;
      endcase
      strobe_d = (state_d != ST_STROBE);
   end

   // Flush wins over a concurrent write; a byte popped in the same cycle still goes out.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk32) begin
      if (push) fifo_mem[wr_ptr_q] <= bus.wr_data;
   end

   always_comb begin
      busy_m_d   = bus.pp_busy;
      busy_s_d   = busy_m_q;
      stb_m_d    = bus.pp_strobe_in;
      stb_s_d    = stb_m_q;
      stb_p_d    = stb_s_q;
      cap_d      = stb_p_q && !stb_s_q && mode_q;
      rd_valid_d = cap_q;
      rd_data_d  = cap_q ? bus.pp_data_in : rd_data_q;
      mode_d     = (state_q == ST_IDLE && state_d == ST_IDLE) ? bus.mode : mode_q;
      oe_d       = !mode_d;
      timeout_d  = tmo_set || (timeout_q && !bus.timeout_clr);
      idle_d     = (state_d == ST_IDLE) && (count_d == '0);
   end

   always_ff @(posedge clk32 or negedge por_n) begin
      if (!por_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         tmr_q      <= '0;
         bw_q       <= '0;
         data_q     <= '0;
         rd_data_q  <= '0;
         busy_m_q   <= 1'b0;
         busy_s_q   <= 1'b0;
         stb_m_q    <= 1'b0;
         stb_s_q    <= 1'b0;
         stb_p_q    <= 1'b0;
         cap_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         mode_q     <= 1'b0;
         oe_q       <= 1'b0;
         strobe_q   <= 1'b1;
         timeout_q  <= 1'b0;
         idle_q     <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         tmr_q      <= tmr_d;
         bw_q       <= bw_d;
         data_q     <= data_d;
         rd_data_q  <= rd_data_d;
         busy_m_q   <= busy_m_d;
         busy_s_q   <= busy_s_d;
         stb_m_q    <= stb_m_d;
         stb_s_q    <= stb_s_d;
         stb_p_q    <= stb_p_d;
         cap_q      <= cap_d;
         rd_valid_q <= rd_valid_d;
         mode_q     <= mode_d;
         oe_q       <= oe_d;
         strobe_q   <= strobe_d;
         timeout_q  <= timeout_d;
         idle_q     <= idle_d;
      end
   end

   assign bus.full          = full;
   assign bus.level         = count_q;
   assign bus.idle          = idle_q;
   assign bus.timeout       = timeout_q;
   assign bus.rd_valid      = rd_valid_q;
   assign bus.rd_data       = rd_data_q;
   assign bus.pp_data_oe    = oe_q;
   assign bus.pp_strobe_oe  = oe_q;
   assign bus.pp_data_out   = data_q;
   assign bus.pp_strobe_out = strobe_q;
endmodule

// File: tb/tb_parport_engine.sv
// Directed bench for parport_engine: timing, FIFO order/full, busy timeout,
// busy during strobe, input capture and asynchronous reset.
module tb_parport_engine;
   localparam int DW = 8;
   localparam int FD = 16;
   localparam int TW = 8;

   logic clk32 = 1'b0;
   logic por_n;
   int   checks   = 0;
   int   failures = 0;
   int   n, lows, pulses;
   logic [7:0] cap_byte;

   parport_engine_if #(.DATA_W(DW), .FIFO_DEPTH(FD)) bus ();

   parport_engine #(
      .DATA_W(DW), .FIFO_DEPTH(FD), .SETUP_CYC(16), .STROBE_CYC(32),
      .HOLD_CYC(16), .TIMEOUT_W(TW)
   ) dut (
      .clk32 (clk32),
      .por_n (por_n),
      .bus   (bus.slave)
   );

   always #5 clk32 = ~clk32;

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task tick();
      @(posedge clk32);
      #1;
   endtask

   task automatic wait_strobe(input logic lvl, input int budget, output int cnt);
      cnt = 0;
      while (bus.pp_strobe_out !== lvl && cnt < budget) begin
         cnt++;
         tick();
      end
      if (cnt >= budget) begin
         checks++;
         failures++;
         $error("FAIL strobe_wait observed=no_edge expected=strobe_%0d", lvl);
      end
   endtask

   task automatic wait_idle(input int budget, output int cnt);
      cnt = 0;
      while (bus.idle !== 1'b1 && cnt < budget) begin
         cnt++;
         tick();
      end
   endtask

   task automatic push(input logic [7:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      tick();
      bus.wr_en   = 1'b0;
   endtask

   initial begin
      bus.wr_en = 0; bus.wr_data = 0; bus.flush = 0; bus.mode = 0;
      bus.timeout_clr = 0; bus.pp_data_in = 0; bus.pp_strobe_in = 1; bus.pp_busy = 0;
      por_n = 1'b1;
      #1 por_n = 1'b0;
      #20;
      chk("rst_level",    32'(bus.level), 0);
      chk("rst_full",     32'(bus.full), 0);
      chk("rst_idle",     32'(bus.idle), 0);
      chk("rst_timeout",  32'(bus.timeout), 0);
      chk("rst_rd_valid", 32'(bus.rd_valid), 0);
      chk("rst_rd_data",  32'(bus.rd_data), 0);
      chk("rst_data_out", 32'(bus.pp_data_out), 0);
      chk("rst_strobe",   32'(bus.pp_strobe_out), 1);
      chk("rst_data_oe",  32'(bus.pp_data_oe), 0);
      chk("rst_strb_oe",  32'(bus.pp_strobe_oe), 0);
      tick();
      por_n = 1'b1;
      tick();
      chk("oe_after_rst", 32'({bus.pp_data_oe, bus.pp_strobe_oe}), 32'h3);
      chk("idle_after_rst", 32'(bus.idle), 1);

      // single byte timing
      tick(); tick();
      push(8'hA5);
      chk("t1_level_n1", 32'(bus.level), 1);
      chk("t1_data_n1",  32'(bus.pp_data_out), 0);
      tick();
      chk("t1_data_n2",  32'(bus.pp_data_out), 32'hA5);
      chk("t1_level_n2", 32'(bus.level), 0);
      wait_strobe(1'b0, 200, n);
      chk("t1_setup_len", 32'(n), 17);
      chk("t1_data_fall", 32'(bus.pp_data_out), 32'hA5);
      wait_strobe(1'b1, 200, n);
      chk("t1_strobe_len", 32'(n), 32);
      chk("t1_data_rise", 32'(bus.pp_data_out), 32'hA5);
      wait_idle(200, n);
      chk("t1_hold_len", 32'(n), 16);
      chk("t1_data_after", 32'(bus.pp_data_out), 32'hA5);

      // fill FIFO back-to-back, overflow write dropped, order preserved
      for (int i = 0; i < 17; i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_data = 8'(8'h40 + i);
         tick();
      end
      chk("t2_full",  32'(bus.full), 1);
      chk("t2_level", 32'(bus.level), 16);
      bus.wr_data = 8'hEE;
      tick();
      bus.wr_en = 1'b0;
      chk("t2_level_drop", 32'(bus.level), 16);
      for (int i = 0; i < 17; i++) begin
         wait_strobe(1'b0, 300, n);
         chk("t2_order", 32'(bus.pp_data_out), 32'(8'h40 + i));
         wait_strobe(1'b1, 300, n);
      end
      wait_idle(300, n);
      chk("t2_idle_end",  32'(bus.idle), 1);
      chk("t2_level_end", 32'(bus.level), 0);

      // busy timeout
      bus.pp_busy = 1'b1;
      tick(); tick(); tick();
      push(8'h77);
      tick();
      chk("t3_data", 32'(bus.pp_data_out), 32'h77);
      n = 0; lows = 0;
      while (bus.timeout !== 1'b1 && n < 600) begin
         n++;
         tick();
         if (bus.pp_strobe_out === 1'b0) lows++;
      end
      chk("t3_timeout_cyc", 32'(n), 255);
      chk("t3_no_strobe", 32'(lows), 0);
      for (int k = 0; k < 20; k++) tick();
      chk("t3_still_high", 32'(bus.pp_strobe_out), 1);
      bus.pp_busy = 1'b0;
      wait_strobe(1'b0, 100, n);
      chk("t3_sent_data", 32'(bus.pp_data_out), 32'h77);
      wait_strobe(1'b1, 100, n);
      chk("t3_strobe_len", 32'(n), 32);
      chk("t3_sticky", 32'(bus.timeout), 1);
      bus.timeout_clr = 1'b1;
      tick();
      bus.timeout_clr = 1'b0;
      chk("t3_cleared", 32'(bus.timeout), 0);
      wait_idle(100, n);

      // busy rising mid-strobe
      push(8'h11);
      push(8'h22);
      wait_strobe(1'b0, 100, n);
      chk("t4_data1", 32'(bus.pp_data_out), 32'h11);
      for (int k = 0; k < 5; k++) tick();
      bus.pp_busy = 1'b1;
      wait_strobe(1'b1, 100, n);
      chk("t4_strobe_len", 32'(n + 5), 32);
      n = 0;
      while (bus.pp_data_out !== 8'h22 && n < 100) begin
         n++;
         tick();
      end
      chk("t4_data2_loaded", 32'(bus.pp_data_out), 32'h22);
      lows = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (bus.pp_strobe_out === 1'b0) lows++;
      end
      chk("t4_waits_busy", 32'(lows), 0);
      bus.pp_busy = 1'b0;
      wait_strobe(1'b0, 100, n);
      chk("t4_data2_sent", 32'(bus.pp_data_out), 32'h22);
      wait_strobe(1'b1, 100, n);
      chk("t4_strobe2_len", 32'(n), 32);
      wait_idle(100, n);

      // input mode capture
      bus.mode = 1'b1;
      tick(); tick();
      chk("t5_oe", 32'({bus.pp_data_oe, bus.pp_strobe_oe}), 0);
      push(8'h99);
      tick(); tick(); tick();
      chk("t5_level_held", 32'(bus.level), 1);
      bus.pp_data_in   = 8'h3C;
      bus.pp_strobe_in = 1'b0;
      pulses = 0; cap_byte = 8'h00;
      for (int k = 0; k < 12; k++) begin
         if (k == 3) bus.pp_strobe_in = 1'b1;
         tick();
         if (bus.rd_valid === 1'b1) begin
            pulses++;
            cap_byte = bus.rd_data;
         end
      end
      chk("t5_pulses",  32'(pulses), 1);
      chk("t5_rd_data", 32'(cap_byte), 32'h3C);
      chk("t5_rd_hold", 32'(bus.rd_data), 32'h3C);
      chk("t5_level",   32'(bus.level), 1);
      chk("t5_no_strobe", 32'(bus.pp_strobe_out), 1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("t5_flush_level", 32'(bus.level), 0);
      chk("t5_flush_idle",  32'(bus.idle), 1);
      bus.mode = 1'b0;
      tick();
      chk("t5_oe_back", 32'({bus.pp_data_oe, bus.pp_strobe_oe}), 32'h3);

      // asynchronous reset mid-strobe
      push(8'h5A);
      push(8'h6B);
      wait_strobe(1'b0, 100, n);
      chk("t6_data", 32'(bus.pp_data_out), 32'h5A);
      chk("t6_level_pre", 32'(bus.level), 1);
      tick(); tick(); tick();
      #3 por_n = 1'b0;
      #1;
      chk("t6_strobe_rst", 32'(bus.pp_strobe_out), 1);
      chk("t6_oe_rst", 32'({bus.pp_data_oe, bus.pp_strobe_oe}), 0);
      chk("t6_level_rst", 32'(bus.level), 0);
      chk("t6_data_rst", 32'(bus.pp_data_out), 0);
      tick();
      por_n = 1'b1;
      tick();
      chk("t6_level_after", 32'(bus.level), 0);
      chk("t6_oe_after", 32'({bus.pp_data_oe, bus.pp_strobe_oe}), 32'h3);
      lows = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (bus.pp_strobe_out === 1'b0) lows++;
      end
      chk("t6_no_resend", 32'(lows), 0);
      chk("t6_idle", 32'(bus.idle), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
